// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// FSM state codes and the default datapath width.
package mips_pkg;

  localparam int MD_NB_DATA = 32;

  // Operation select as decoded from the MULT/MULTU/DIV/DIVU funct field
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  // Iteration FSM states
  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_CALC  = 2'b01,
    MD_FIXUP = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation. Used to turn signed operands into
// magnitudes on entry and to put the signs back on the result in FIXUP.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] value_o
);

  // Negate when asked, otherwise pass through unchanged
  always_comb begin
    value_o = value_i;
    if (negate_i) begin
      value_o = ~value_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring-divide step per cycle on operand
// magnitudes; signs are re-applied in a registered FIXUP step before the
// HI/LO write so the wide negate never sits on the HI/LO write path.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int NB_DATA = MD_NB_DATA,
  parameter int NB_OP   = 2,
  parameter int NB_CNT  = 6
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [NB_OP-1:0]   op_i,
  input  logic [NB_DATA-1:0] rs_data_i,
  input  logic [NB_DATA-1:0] rt_data_i,
  input  logic               flush_i,
  input  logic               mthi_i,
  input  logic               mtlo_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [NB_DATA-1:0] hi_o,
  output logic [NB_DATA-1:0] lo_o
);

  localparam int NB_ACC = 2 * NB_DATA;

  md_state_e           state_reg;
  md_state_e           state_next;
  logic [NB_CNT-1:0]   cnt_reg;
  logic [NB_ACC-1:0]   acc_reg;      // {upper, lower}: product, or {remainder, quotient}
  logic [NB_DATA-1:0]  operand_reg;  // multiplicand or divisor magnitude
  logic                is_div_reg;
  logic                neg_lo_reg;   // negate product (mult) or quotient (div)
  logic                neg_hi_reg;   // negate remainder (div only)
  logic                fix_wr_reg;   // FIXUP second cycle: signed result ready in acc
  logic                done_reg;
  logic [NB_DATA-1:0]  hi_reg;
  logic [NB_DATA-1:0]  lo_reg;

  // Entry decode
  logic [1:0]          op_sel;
  logic                op_div;
  logic                op_signed;
  logic                rs_neg;
  logic                rt_neg;
  logic                rt_zero;
  logic [NB_DATA-1:0]  rs_mag;
  logic [NB_DATA-1:0]  rt_mag;

  // Iteration datapath
  logic [NB_DATA:0]    mul_sum;
  logic [NB_DATA:0]    div_trial;
  logic [NB_DATA:0]    div_diff;
  logic                div_ge;
  logic [NB_ACC-1:0]   step_acc;

  // Sign re-application
  logic [NB_ACC-1:0]   prod_fixed;
  logic [NB_DATA-1:0]  quo_fixed;
  logic [NB_DATA-1:0]  rem_fixed;

  assign op_sel    = op_i[1:0];
  assign op_div    = (op_sel == MD_DIVU) || (op_sel == MD_DIV);
  assign op_signed = (op_sel == MD_MULT) || (op_sel == MD_DIV);
  assign rs_neg    = op_signed & rs_data_i[NB_DATA-1];
  assign rt_neg    = op_signed & rt_data_i[NB_DATA-1];
  assign rt_zero   = (rt_data_i == '0);

  md_sign_fix #(.WIDTH(NB_DATA)) u_rs_mag (
    .value_i (rs_data_i),
    .negate_i(rs_neg),
    .value_o (rs_mag)
  );

  md_sign_fix #(.WIDTH(NB_DATA)) u_rt_mag (
    .value_i (rt_data_i),
    .negate_i(rt_neg),
    .value_o (rt_mag)
  );

  md_sign_fix #(.WIDTH(NB_ACC)) u_prod_fix (
    .value_i (acc_reg),
    .negate_i(neg_lo_reg),
    .value_o (prod_fixed)
  );

  md_sign_fix #(.WIDTH(NB_DATA)) u_quo_fix (
    .value_i (acc_reg[NB_DATA-1:0]),
    .negate_i(neg_lo_reg),
    .value_o (quo_fixed)
  );

  md_sign_fix #(.WIDTH(NB_DATA)) u_rem_fix (
    .value_i (acc_reg[NB_ACC-1:NB_DATA]),
    .negate_i(neg_hi_reg),
    .value_o (rem_fixed)
  );

  // One multiply or divide step; the divide borrow bit doubles as the compare
  always_comb begin
    mul_sum   = {1'b0, acc_reg[NB_ACC-1:NB_DATA]}
              + (acc_reg[0] ? {1'b0, operand_reg} : {(NB_DATA+1){1'b0}});
    div_trial = acc_reg[NB_ACC-1:NB_DATA-1];
    div_diff  = div_trial - {1'b0, operand_reg};
    div_ge    = ~div_diff[NB_DATA];
    if (is_div_reg) begin
      step_acc = {(div_ge ? div_diff[NB_DATA-1:0] : div_trial[NB_DATA-1:0]),
                  acc_reg[NB_DATA-2:0], div_ge};
    end else begin
      step_acc = {mul_sum, acc_reg[NB_DATA-1:1]};
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= MD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; flush always wins
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          state_next = MD_CALC;
        end
      end
      MD_CALC: begin
        if (flush_i) begin
          state_next = MD_IDLE;
        end else if (cnt_reg == NB_CNT'(1)) begin
          state_next = MD_FIXUP;
        end
      end
      MD_FIXUP: begin
        if (flush_i || fix_wr_reg) begin
          state_next = MD_IDLE;
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_reg != MD_IDLE);
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_reg     <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      is_div_reg  <= 1'b0;
      neg_lo_reg  <= 1'b0;
      neg_hi_reg  <= 1'b0;
      fix_wr_reg  <= 1'b0;
      done_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (mthi_i) begin
            hi_reg <= rs_data_i;
          end
          if (mtlo_i) begin
            lo_reg <= rs_data_i;
          end
          if (start_i && !flush_i) begin
            cnt_reg     <= NB_CNT'(NB_DATA);
            acc_reg     <= {{NB_DATA{1'b0}}, (op_div ? rs_mag : rt_mag)};
            operand_reg <= op_div ? rt_mag : rs_mag;
            is_div_reg  <= op_div;
            // A zero divisor keeps the all-ones quotient unsigned; the
            // remainder sign fix then reproduces the original dividend.
            neg_lo_reg  <= (rs_neg ^ rt_neg) & ~(op_div & rt_zero);
            neg_hi_reg  <= op_div & rs_neg;
            fix_wr_reg  <= 1'b0;
          end
        end
        MD_CALC: begin
          if (flush_i) begin
            cnt_reg <= '0;
          end else begin
            acc_reg <= step_acc;
            cnt_reg <= cnt_reg - NB_CNT'(1);
          end
        end
        MD_FIXUP: begin
          if (flush_i) begin
            fix_wr_reg <= 1'b0;
          end else if (!fix_wr_reg) begin
            acc_reg    <= is_div_reg ? {rem_fixed, quo_fixed} : prod_fixed;
            fix_wr_reg <= 1'b1;
          end else begin
            hi_reg     <= acc_reg[NB_ACC-1:NB_DATA];
            lo_reg     <= acc_reg[NB_DATA-1:0];
            done_reg   <= 1'b1;
            fix_wr_reg <= 1'b0;
          end
        end
        default: begin
          fix_wr_reg <= 1'b0;
        end
      endcase
    end
  end

  assign done_o = done_reg;
  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO pushed to a scoreboard at
// launch and popped when done_o fires; latency, busy span, side inputs,
// flush and asynchronous reset are checked inline.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        flush = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  mult_div_unit dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .start_i  (start),
    .op_i     (op),
    .rs_data_i(rs),
    .rt_data_i(rt),
    .flush_i  (flush),
    .mthi_i   (mthi),
    .mtlo_i   (mtlo),
    .busy_o   (busy),
    .done_o   (done),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain 64-bit arithmetic
  function automatic logic [63:0] md_model(input logic [1:0] mop, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] qa;
    logic signed [31:0] qb;
    logic [63:0]        res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    case (mop)
      2'b00: res = {32'd0, a} * {32'd0, b};
      2'b01: res = sa * sb;
      2'b10: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0)                                  res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == '1)      res = {32'd0, 32'h8000_0000};
        else                                         res = {32'(qa % qb), 32'(qa / qb)};
      end
    endcase
    return res;
  endfunction

  // Launch one operation, wait (bounded) for done_o, check timing and result
  task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    exp_t e;
    int   lat;
    int   busy_cnt;
    e.tag = tag;
    e.hi  = exp_hi;
    e.lo  = exp_lo;
    sb_q.push_back(e);
    op    = mop;
    rs    = a;
    rt    = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    rs    = $urandom;
    rt    = $urandom;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, 32'(lat), 32'd34);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd34);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    e = sb_q.pop_front();
    check({e.tag, " hi"}, hi, e.hi);
    check({e.tag, " lo"}, lo, e.lo);
    $display("op=%0d rs=0x%08h rt=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d (%s)",
             mop, a, b, hi, lo, lat, e.tag);
    tick();
    check({tag, " done_width"}, 32'(done), 32'd0);
  endtask

  task automatic run_model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
    logic [63:0] r;
    r = md_model(mop, a, b);
    run_op(mop, a, b, r[63:32], r[31:0], tag);
  endtask

  initial begin
    int done_seen;

    // Reset state
    #12;
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Directed arithmetic cases
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(2'b10, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2");
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_by0");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by0");
    run_op(2'b11, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, "div_pos_neg");

    // Randomised operands against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      run_model(2'(i), $urandom, (i >= 6) ? 32'($urandom_range(1, 1000)) : $urandom,
                $sformatf("rand%0d", i));
    end

    // Side inputs and flush during a busy period
    rs = 32'h1234; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_init hi", hi, 32'h1234);
    check("mt_init lo", lo, 32'h1234);
    op = 2'b00; rs = 32'd3; rt = 32'd4; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();      // E1..E4
    mthi = 1'b1; start = 1'b1; rs = 32'hDEAD; rt = 32'd1;
    tick();                                   // E5
    mthi = 1'b0; start = 1'b0;
    check("busy_mthi hi", hi, 32'h1234);
    check("busy_mthi busy", 32'(busy), 32'd1);
    for (int c = 6; c <= 9; c++) tick();      // E6..E9
    flush = 1'b1;
    tick();                                   // E10
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) done_seen++;
    end
    check("flush no_done", 32'(done_seen), 32'd0);
    check("flush hi", hi, 32'h1234);
    check("flush lo", lo, 32'h1234);
    check("flush idle", 32'(busy), 32'd0);
    $display("flush: hi=0x%08h lo=0x%08h busy=%0d done_seen=%0d", hi, lo, busy, done_seen);
    rs = 32'hABCD; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    check("mtlo lo", lo, 32'hABCD);
    check("mtlo hi", hi, 32'h1234);

    // Flush together with start in IDLE: nothing launches
    op = 2'b00; rs = 32'd9; rt = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a DIV
    op = 2'b11; rs = 32'd100; rt = 32'd7; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    for (int c = 1; c <= 20; c++) tick();     // E1..E20
    #2;
    reset_n = 1'b0;
    #1;
    check("areset busy", 32'(busy), 32'd0);
    check("areset done", 32'(done), 32'd0);
    check("areset hi", hi, 32'd0);
    check("areset lo", lo, 32'd0);
    $display("async reset: busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "multu_after_rst");

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative MIPS multiply/divide unit for MULT, MULTU, DIV and DIVU, with HI/LO storage. It sits in the EX stage directly downstream of the rs/rt forwarding multiplexers and consumes their selected operand outputs. It runs a 32-iteration shift-add or restoring-divide datapath. It exposes `busy_o` so the hazard logic can stall MFHI/MFLO and new mult/div instructions, and it holds the architectural HI/LO registers.

## Interface
Parameters:
- `NB_DATA`, 32, operand and HI/LO width
- `NB_OP`, 2, operation-select width
- `NB_CNT`, 6, iteration-counter width; must hold NB_DATA

Ports:
- `clk_i`  in  1  clock, rising edge
- `reset_n_i`  in  1  asynchronous, active-low reset
- `start_i`  in  1  launch the operation in `op_i`; sampled only in IDLE
- `op_i`  in  NB_OP  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `rs_data_i`  in  NB_DATA  multiplicand or dividend, from the rs forwarding mux
- `rt_data_i`  in  NB_DATA  multiplier or divisor, from the rt forwarding mux
- `flush_i`  in  1  abort the in-flight operation (branch or exception squash)
- `mthi_i`  in  1  write `rs_data_i` to HI
- `mtlo_i`  in  1  write `rs_data_i` to LO
- `busy_o`  out  1  operation in progress
- `done_o`  out  1  one-cycle pulse: HI/LO just updated by an operation
- `hi_o`  out  NB_DATA  HI register
- `lo_o`  out  NB_DATA  LO register

## Operation
- FSM states: IDLE, CALC, FIXUP.
  - IDLE → CALC on `start_i & ~flush_i`. Operands and op are latched. Signed ops latch magnitudes plus result-sign flags; the counter loads NB_DATA.
  - CALC: one iteration per cycle; the counter decrements. CALC → FIXUP when the counter reaches 1.
  - FIXUP: apply the signs, write HI/LO, go to IDLE.
- Multiply: 2·NB_DATA-bit shift-add on magnitudes.
  - MULT product is negated when the operand signs differ.
  - HI = upper half, LO = lower half.
- Divide: restoring division on magnitudes. LO = quotient, HI = remainder.
  - DIV: quotient is negated when the signs differ.
  - DIV: remainder takes the dividend's sign.
- Divide by zero, both DIV and DIVU:
  - LO = all ones, HI = `rs_data_i` as latched.
  - No exception is raised; latency is normal.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0 (truncated result).
- `start_i` while busy: ignored; no queueing.
- `mthi_i`/`mtlo_i`:
  - In IDLE: the write takes effect at the next edge.
  - While busy: ignored.
  - If asserted together with `start_i`: both take effect. The operation result later overwrites HI/LO.
- `flush_i`:
  - From CALC or FIXUP: return to IDLE next edge. HI/LO are unchanged and no `done_o` is produced.
  - Together with `start_i` in IDLE: flush wins and nothing launches.
- Reset (async, any state): state IDLE, counter 0, HI = LO = 0, `busy_o` = 0, `done_o` = 0.

## Timing
- Start sampled at edge E0. CALC occupies edges E1..E32; FIXUP is at E33.
- HI/LO are written and `done_o` is registered high at edge E34. `done_o` is high for exactly the cycle after E34.
- Start-to-result latency is 34 cycles. Back-to-back starts can begin at the earliest in the `done_o` cycle.
- `busy_o` is registered: high from E0+ through E34−. Equivalent to `state != IDLE`.
- `hi_o`/`lo_o` are direct register outputs with no combinational path from the inputs.
- Operand inputs are don't-care after E0.

## Structure
- Shared package `mips_pkg`:
  - op encodings `MD_MULTU`, `MD_MULT`, `MD_DIVU`, `MD_DIV`
  - FSM state encodings `MD_IDLE`, `MD_CALC`, `MD_FIXUP`
  - `NB_DATA` default
- One sub-module is natural: `md_sign_fix`, a combinational magnitude/sign conversion used on entry and in FIXUP.
- Everything else is flat: the FSM, counter, 2·NB_DATA accumulator and HI/LO registers.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001; `done_o` 34 cycles after start; `busy_o` high for 34 cycles.
- MULT 0xFFFF_FFFD (−3) × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB.
- DIV 0xFFFF_FFF9 (−7) / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIVU 7 / 2 → LO = 3, HI = 1.
- DIVU 5 / 0 → LO = 0xFFFF_FFFF, HI = 5. DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
- Busy-period side inputs and flush, starting from HI = LO = 0x1234:
  - With HI = LO = 0x1234, start MULTU 3×4.
  - Pulse `mthi_i` and `start_i` at cycle 5 → both ignored.
  - Pulse `flush_i` at cycle 10 → `busy_o` low next cycle, no `done_o`, HI/LO stay 0x1234.
  - Then in IDLE, `mtlo_i` with rs = 0xABCD → LO = 0xABCD one cycle later.
- Mid-operation reset:
  - Assert `reset_n_i` low at cycle 20 of a DIV → all outputs 0 immediately, without a clock edge.
  - After release, a new MULTU 2×3 gives LO = 6, HI = 0.
